// File: rtl/alu_issue.sv
// alu_issue: decodes a MIPS-style ALU instruction, drives operands and an
// operation select into an external registered ALU, waits out the ALU
// latency and returns the result through a valid/ready response channel.
module alu_issue #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [15:0] req_imm,
    output logic [3:0]  alu_cntrl,
    output logic [31:0] data_1,
    output logic [31:0] data_2,
    input  logic [31:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_branch,
    output logic        rsp_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;

    // WAIT counts down from ALU_LAT to 0, so WAIT lasts ALU_LAT+1 cycles.
    localparam logic [2:0] WAIT_LOAD = 3'(ALU_LAT);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_req_ready;
    logic [2:0]  r_wait_cnt;
    logic [3:0]  r_alu_cntrl;
    logic [31:0] r_data_1;
    logic [31:0] r_data_2;
    logic        r_is_beq;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_result;
    logic        r_rsp_zero;
    logic        r_rsp_branch;
    logic        r_rsp_err;

    logic        w_legal;
    logic        w_is_beq;
    logic        w_use_b;
    logic        w_sext;
    logic [3:0]  w_cntrl;
    logic [31:0] w_imm_ext;
    logic [31:0] w_data_2;
    logic        w_accept;
    logic        w_wait_done;
    logic        w_alu_zero;

    assign w_accept    = req_valid && r_req_ready;
    assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == 3'd0);
    assign w_alu_zero  = (alu_out == 32'd0);

    // Instruction decode: legality, ALU select, operand-2 source and extension.
    always_comb begin
        w_legal  = 1'b0;
        w_is_beq = 1'b0;
        w_use_b  = 1'b0;
        w_sext   = 1'b0;
        w_cntrl  = ALU_AND;
        case (req_op)
            6'b000000: begin
                w_use_b = 1'b1;
                case (req_funct)
                    6'b100100: begin w_legal = 1'b1; w_cntrl = ALU_AND; end
                    6'b100101: begin w_legal = 1'b1; w_cntrl = ALU_OR;  end
                    6'b100000: begin w_legal = 1'b1; w_cntrl = ALU_ADD; end
                    6'b100010: begin w_legal = 1'b1; w_cntrl = ALU_SUB; end
                    6'b011000: begin w_legal = 1'b1; w_cntrl = ALU_MUL; end
                    default:   begin w_legal = 1'b0; w_cntrl = ALU_AND; end
                endcase
            end
            6'b001000: begin w_legal = 1'b1; w_cntrl = ALU_ADD; w_sext = 1'b1; end
            6'b001100: begin w_legal = 1'b1; w_cntrl = ALU_AND; end
            6'b001101: begin w_legal = 1'b1; w_cntrl = ALU_OR;  end
            6'b100011: begin w_legal = 1'b1; w_cntrl = ALU_ADD; w_sext = 1'b1; end
            6'b101011: begin w_legal = 1'b1; w_cntrl = ALU_ADD; w_sext = 1'b1; end
            6'b000100: begin
                w_legal  = 1'b1;
                w_cntrl  = ALU_SUB;
                w_use_b  = 1'b1;
                w_is_beq = 1'b1;
            end
            default: begin w_legal = 1'b0; end
        endcase
    end

    // Operand-2 selection: rt value or the sign/zero-extended immediate.
    always_comb begin
        if (w_sext) begin
            w_imm_ext = {{16{req_imm[15]}}, req_imm};
        end else begin
            w_imm_ext = {16'h0000, req_imm};
        end
        if (w_use_b) begin
            w_data_2 = req_b;
        end else begin
            w_data_2 = w_imm_ext;
        end
    end

    // Next-state logic; illegal instructions skip straight to RESP.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; ready is registered so it is only high while sitting in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // WAIT down-counter: loaded leaving ISSUE, decremented while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 3'd0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= WAIT_LOAD;
        end else if ((r_state == S_WAIT) && (r_wait_cnt != 3'd0)) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // ALU drive registers: loaded only on a legal acceptance, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_cntrl <= 4'b0000;
            r_data_1    <= 32'd0;
            r_data_2    <= 32'd0;
            r_is_beq    <= 1'b0;
        end else if ((r_state == S_IDLE) && w_accept && w_legal) begin
            r_alu_cntrl <= w_cntrl;
            r_data_1    <= req_a;
            r_data_2    <= w_data_2;
            r_is_beq    <= w_is_beq;
        end else begin
            r_alu_cntrl <= r_alu_cntrl;
            r_data_1    <= r_data_1;
            r_data_2    <= r_data_2;
            r_is_beq    <= r_is_beq;
        end
    end

    // Response registers: error response on illegal accept, ALU capture at end of WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_zero   <= 1'b0;
            r_rsp_branch <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else if ((r_state == S_IDLE) && w_accept && !w_legal) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= 32'd0;
            r_rsp_zero   <= 1'b0;
            r_rsp_branch <= 1'b0;
            r_rsp_err    <= 1'b1;
        end else if (w_wait_done) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= alu_out;
            r_rsp_zero   <= w_alu_zero;
            r_rsp_branch <= r_is_beq && w_alu_zero;
            r_rsp_err    <= 1'b0;
        end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= r_rsp_result;
            r_rsp_zero   <= r_rsp_zero;
            r_rsp_branch <= r_rsp_branch;
            r_rsp_err    <= r_rsp_err;
        end else begin
            r_rsp_valid  <= r_rsp_valid;
            r_rsp_result <= r_rsp_result;
            r_rsp_zero   <= r_rsp_zero;
            r_rsp_branch <= r_rsp_branch;
            r_rsp_err    <= r_rsp_err;
        end
    end

    assign req_ready  = r_req_ready;
    assign alu_cntrl  = r_alu_cntrl;
    assign data_1     = r_data_1;
    assign data_2     = r_data_2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_branch = r_rsp_branch;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a timed behavioural model checked every cycle,
// directed literal cases, randomized ops, a reset-abort case and an
// ALU_LAT=3 instance for latency.
module tb_alu_issue;

    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [5:0]  req_op, req_funct;
    logic [31:0] req_a, req_b;
    logic [15:0] req_imm;
    logic [3:0]  alu_cntrl;
    logic [31:0] data_1, data_2, alu_out;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_branch, rsp_err;

    logic        req_valid3, req_ready3;
    logic [3:0]  alu_cntrl3;
    logic [31:0] data_1_3, data_2_3, alu_out3;
    logic        rsp_valid3, rsp_ready3;
    logic [31:0] rsp_result3;
    logic        rsp_zero3, rsp_branch3, rsp_err3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue #(.ALU_LAT(LAT1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .req_imm(req_imm), .alu_cntrl(alu_cntrl), .data_1(data_1), .data_2(data_2),
        .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_branch(rsp_branch),
        .rsp_err(rsp_err)
    );

    alu_issue #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .req_imm(req_imm), .alu_cntrl(alu_cntrl3), .data_1(data_1_3), .data_2(data_2_3),
        .alu_out(alu_out3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_zero(rsp_zero3), .rsp_branch(rsp_branch3),
        .rsp_err(rsp_err3)
    );

    // External ALU models: 1 and 3 register stages.
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            4'd0: return x & y;
            4'd1: return x | y;
            4'd2: return x + y;
            4'd3: return x - y;
            4'd4: return x * y;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] p3 [3];
    always @(posedge clk) alu_out <= alu_f(alu_cntrl, data_1, data_2);
    always @(posedge clk) begin
        p3[0] <= alu_f(alu_cntrl3, data_1_3, data_2_3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign alu_out3 = p3[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Instruction semantics straight from the ISA description.
    function automatic void ref_op(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                                   output logic legal, output logic beq, output logic [3:0] c,
                                   output logic [31:0] d2, output logic [31:0] res);
        logic [31:0] se, ze;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0000, imm};
        legal = 1'b1; beq = 1'b0; c = 4'd0; d2 = b; res = 32'd0;
        if (op == 6'h00) begin
            case (fn)
                6'h24: begin c = 4'd0; res = a & b; end
                6'h25: begin c = 4'd1; res = a | b; end
                6'h20: begin c = 4'd2; res = a + b; end
                6'h22: begin c = 4'd3; res = a - b; end
                6'h18: begin c = 4'd4; res = a * b; end
                default: legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: begin c = 4'd2; d2 = se; res = a + se; end
                6'h0C: begin c = 4'd0; d2 = ze; res = a & ze; end
                6'h0D: begin c = 4'd1; d2 = ze; res = a | ze; end
                6'h23, 6'h2B: begin c = 4'd2; d2 = se; res = a + se; end
                6'h04: begin c = 4'd3; d2 = b; res = a - b; beq = 1'b1; end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) res = 32'd0;
    endfunction

    // Timed model: expected outputs for the upcoming cycle.
    logic        m_ready, m_rv, m_z, m_br, m_err, p_beq;
    int          m_wait;
    logic [3:0]  m_c;
    logic [31:0] m_d1, m_d2, m_res, p_res;

    initial begin : cmp
        logic lg, bq;
        logic [3:0] c;
        logic [31:0] d2, r;
        m_ready = 1'b0; m_rv = 1'b0; m_z = 1'b0; m_br = 1'b0; m_err = 1'b0; p_beq = 1'b0;
        m_wait = 0; m_c = 4'd0; m_d1 = 32'd0; m_d2 = 32'd0; m_res = 32'd0; p_res = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ready = 1'b0; m_rv = 1'b0; m_z = 1'b0; m_br = 1'b0; m_err = 1'b0;
                m_wait = 0; m_c = 4'd0; m_d1 = 32'd0; m_d2 = 32'd0; m_res = 32'd0;
            end
            check("req_ready", req_ready, m_ready);
            check("rsp_valid", rsp_valid, m_rv);
            check("alu_cntrl", alu_cntrl, m_c);
            check("data_1", data_1, m_d1);
            check("data_2", data_2, m_d2);
            if (m_rv || !rst_n) begin
                check("rsp_result", rsp_result, m_res);
                check("rsp_zero", rsp_zero, m_z);
                check("rsp_branch", rsp_branch, m_br);
                check("rsp_err", rsp_err, m_err);
            end
            if (rst_n) begin
                if (m_rv) begin
                    if (rsp_ready) begin m_rv = 1'b0; m_ready = 1'b1; end
                end else if (m_wait > 0) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_rv = 1'b1; m_res = p_res; m_z = (p_res == 32'd0);
                        m_br = p_beq && (p_res == 32'd0); m_err = 1'b0;
                    end
                end else if (m_ready && req_valid) begin
                    ref_op(req_op, req_funct, req_a, req_b, req_imm, lg, bq, c, d2, r);
                    m_ready = 1'b0;
                    if (lg) begin
                        m_c = c; m_d1 = req_a; m_d2 = d2;
                        p_res = r; p_beq = bq; m_wait = LAT1 + 2;
                    end else begin
                        m_rv = 1'b1; m_res = 32'd0; m_z = 1'b0; m_br = 1'b0; m_err = 1'b1;
                    end
                end else begin
                    m_ready = 1'b1;
                end
            end
        end
    end

    task automatic scramble();
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 6'($urandom);
        req_funct = 6'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        req_imm   = 16'($urandom);
    endtask

    task automatic do_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm, input int hold,
                         output int lat, output logic [31:0] res, output logic z,
                         output logic br, output logic er, output logic [3:0] c,
                         output logic [31:0] d2);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
        if (!req_ready) note_fail("ready_timeout");
        req_valid = 1'b1; req_op = op; req_funct = fn; req_a = a; req_b = b; req_imm = imm;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; scramble(); end
        if (!rsp_valid) note_fail("rsp_timeout");
        lat = n; res = rsp_result; z = rsp_zero; br = rsp_branch; er = rsp_err;
        c = alu_cntrl; d2 = data_2;
        repeat (hold) begin @(posedge clk); #1; scramble(); end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : drv
        int lat, n, k;
        logic [31:0] res, d2, a, b;
        logic z, br, er;
        logic [3:0] c;
        logic [5:0] op, fn;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_valid3 = 1'b0; rsp_ready3 = 1'b0;
        req_op = 6'd0; req_funct = 6'd0; req_a = 32'd0; req_b = 32'd0; req_imm = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("ready_low_after_release", req_ready, 32'd0);
        @(posedge clk); #1;
        check("ready_first_edge", req_ready, 32'd1);

        do_op(6'h00, 6'h20, 32'd5, 32'd7, 16'd0, 0, lat, res, z, br, er, c, d2);
        check("add_lat", lat, 32'd3);
        check("add_res", res, 32'd12);
        check("add_zero", z, 32'd0);
        check("add_err", er, 32'd0);

        do_op(6'h04, 6'h00, 32'h1234, 32'h1234, 16'd0, 0, lat, res, z, br, er, c, d2);
        check("beq_cntrl", c, 32'd3);
        check("beq_res", res, 32'd0);
        check("beq_zero", z, 32'd1);
        check("beq_branch", br, 32'd1);

        do_op(6'h04, 6'h00, 32'h1234, 32'h1235, 16'd0, 0, lat, res, z, br, er, c, d2);
        check("beq_ne_res", res, 32'hFFFFFFFF);
        check("beq_ne_branch", br, 32'd0);

        do_op(6'h08, 6'h00, 32'd1, 32'd99, 16'hFFFF, 0, lat, res, z, br, er, c, d2);
        check("addi_d2", d2, 32'hFFFFFFFF);
        check("addi_res", res, 32'd0);
        check("addi_branch", br, 32'd0);

        do_op(6'h0D, 6'h00, 32'd0, 32'd99, 16'hFFFF, 0, lat, res, z, br, er, c, d2);
        check("ori_d2", d2, 32'h0000FFFF);
        check("ori_res", res, 32'h0000FFFF);

        do_op(6'h3F, 6'h20, 32'd3, 32'd4, 16'd5, 0, lat, res, z, br, er, c, d2);
        check("ill_lat", lat, 32'd0);
        check("ill_err", er, 32'd1);
        check("ill_res", res, 32'd0);
        check("ill_cntrl_kept", c, 32'd1);

        do_op(6'h00, 6'h22, 32'd10, 32'd3, 16'd0, 5, lat, res, z, br, er, c, d2);
        check("hold_res", res, 32'd7);

        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 11);
            a = $urandom; b = $urandom;
            case (k)
                0: begin op = 6'h00; fn = 6'h24; end
                1: begin op = 6'h00; fn = 6'h25; end
                2: begin op = 6'h00; fn = 6'h20; end
                3: begin op = 6'h00; fn = 6'h22; end
                4: begin op = 6'h00; fn = 6'h18; end
                5: begin op = 6'h08; fn = 6'($urandom); end
                6: begin op = 6'h0C; fn = 6'($urandom); end
                7: begin op = 6'h0D; fn = 6'($urandom); end
                8: begin op = 6'h23; fn = 6'($urandom); end
                9: begin op = 6'h2B; fn = 6'($urandom); end
                10: begin op = 6'h04; fn = 6'($urandom); if ($urandom_range(0, 1) == 1) b = a; end
                default: begin op = 6'($urandom); fn = 6'($urandom); end
            endcase
            if ($urandom_range(0, 7) == 0) a = b;
            do_op(op, fn, a, b, 16'($urandom), $urandom_range(0, 3), lat, res, z, br, er, c, d2);
        end

        // Reset while an operation sits in WAIT.
        n = 0;
        while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_op = 6'h00; req_funct = 6'h20; req_a = 32'd9; req_b = 32'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 32'd0);
        check("rst_rsp_valid", rsp_valid, 32'd0);
        check("rst_alu_cntrl", alu_cntrl, 32'd0);
        check("rst_data_1", data_1, 32'd0);
        check("rst_data_2", data_2, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready_first_edge", req_ready, 32'd1);
        n = 0;
        repeat (10) begin @(posedge clk); #1; if (rsp_valid) n++; end
        check("no_rsp_after_reset", n, 32'd0);

        // ALU_LAT=3 instance: latency of five edges after acceptance.
        n = 0;
        while (!req_ready3 && n < 40) begin @(posedge clk); #1; n++; end
        req_op = 6'h00; req_funct = 6'h20; req_a = 32'd5; req_b = 32'd7; req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        n = 0;
        while (!rsp_valid3 && n < 40) begin @(posedge clk); #1; n++; end
        if (!rsp_valid3) note_fail("lat3_timeout");
        check("lat3_edges", n, 32'd5);
        check("lat3_res", rsp_result3, 32'd12);
        check("lat3_err", rsp_err3, 32'd0);
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;
        check("lat3_rsp_done", rsp_valid3, 32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
